// File: rtl/neuron_pkg.sv
// neuron_pkg: shared widths, saturation limits and update FSM states for the neuron datapaths
package neuron_pkg;
   localparam int DATA_W = 8;
   localparam int PROD_W = 16;
   localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, UPD, BIAS} upd_state_t;
endpackage

// File: rtl/neuron_weight_update_if.sv
// neuron_weight_update_if: request, preload-write and result bundle of the weight updater
// master drives start/err/x_flat/wr_*; slave drives weight_flat/bias/busy/done/sat.
interface neuron_weight_update_if
   import neuron_pkg::*;
#(
   parameter int N_INPUTS = 4
);
   logic                         start;
   logic signed [DATA_W-1:0]     err;
   logic [N_INPUTS*DATA_W-1:0]   x_flat;
   logic                         wr_en;
   logic [$clog2(N_INPUTS+1)-1:0] wr_addr;
   logic signed [DATA_W-1:0]     wr_data;
   logic [N_INPUTS*DATA_W-1:0]   weight_flat;
   logic signed [DATA_W-1:0]     bias;
   logic                         busy;
   logic                         done;
   logic                         sat;
   modport master (output start, err, x_flat, wr_en, wr_addr, wr_data,
                   input  weight_flat, bias, busy, done, sat);
   modport slave  (input  start, err, x_flat, wr_en, wr_addr, wr_data,
                   output weight_flat, bias, busy, done, sat);
endinterface

// File: rtl/neuron_weight_update_sat_sub.sv
// sat_sub: combinational a - b on W-bit signed operands, saturated to DATA_W bits
// Ports: a, b (W-bit signed, pre-widened so the subtraction cannot wrap);
//        y (saturated difference), ovf (high when a clamp occurred).
module sat_sub
   import neuron_pkg::*;
#(
   parameter int W = 17
) (
   input  logic signed [W-1:0]      a,
   input  logic signed [W-1:0]      b,
   output logic signed [DATA_W-1:0] y,
   output logic                     ovf
);
   logic signed [W-1:0] d;
   assign d = a - b;
   // In range exactly when every bit above the result's sign bit copies it.
   assign ovf = ~(&d[W-1:DATA_W-1] | ~|d[W-1:DATA_W-1]);
   assign y = ovf ? (d[W-1] ? SAT_MIN : SAT_MAX) : d[DATA_W-1:0];
endmodule

// File: rtl/neuron_weight_update.sv
// neuron_weight_update: holds neuron weights/bias and applies one saturated gradient step per start
// Ports: clk; rst (asynchronous, active high); bus (slave modport of neuron_weight_update_if):
//   start/err/x_flat request an update, wr_en/wr_addr/wr_data preload values in IDLE,
//   weight_flat/bias are the registered parameters, busy/done/sat report progress.
module neuron_weight_update
   import neuron_pkg::*;
#(
   parameter int N_INPUTS   = 4,
   parameter int LR_SHIFT   = 8,
   parameter int BIAS_SHIFT = 2
) (
   input logic clk,
   input logic rst,
   neuron_weight_update_if.slave bus
);
   localparam int IW = N_INPUTS > 1 ? $clog2(N_INPUTS) : 1;
   localparam int AW = $clog2(N_INPUTS + 1);
   upd_state_t state;
   logic signed [DATA_W-1:0] w [N_INPUTS];
   logic signed [DATA_W-1:0] b_q, err_q, x_sel, w_cur, w_new, b_new, b_step;
   logic [N_INPUTS*DATA_W-1:0] x_q;
   logic [IW-1:0] idx;
   logic busy_q, done_q, sat_q, w_ovf, b_ovf;
   logic signed [PROD_W-1:0] prod, delta;
   // One shared arithmetic lane, steered by idx, walks the weights one per cycle.
   assign w_cur  = w[idx];
   assign x_sel  = x_q[idx*DATA_W +: DATA_W];
   assign prod   = PROD_W'(err_q) * PROD_W'(x_sel);
   assign delta  = prod >>> LR_SHIFT;
   assign b_step = err_q >>> BIAS_SHIFT;
   sat_sub #(.W(PROD_W + 1)) u_wsat (
      .a  ({{(PROD_W + 1 - DATA_W){w_cur[DATA_W-1]}}, w_cur}),
      .b  ({delta[PROD_W-1], delta}),
      .y  (w_new),
      .ovf(w_ovf)
   );
   sat_sub #(.W(DATA_W + 1)) u_bsat (
      .a  ({b_q[DATA_W-1], b_q}),
      .b  ({b_step[DATA_W-1], b_step}),
      .y  (b_new),
      .ovf(b_ovf)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         for (int k = 0; k < N_INPUTS; k++) w[k] <= '0;
         b_q    <= '0;
         err_q  <= '0;
         x_q    <= '0;
         idx    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         sat_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  err_q  <= bus.err;
                  x_q    <= bus.x_flat;
                  idx    <= '0;
                  sat_q  <= 1'b0;
                  busy_q <= 1'b1;
                  state  <= UPD;
               end else if (bus.wr_en) begin
                  if (bus.wr_addr < AW'(N_INPUTS)) w[IW'(bus.wr_addr)] <= bus.wr_data;
                  else if (bus.wr_addr == AW'(N_INPUTS)) b_q <= bus.wr_data;
               end
            end
            UPD: begin
               w[idx] <= w_new;
               sat_q  <= sat_q | w_ovf;
               idx    <= idx + IW'(1);
               if (idx == IW'(N_INPUTS - 1)) state <= BIAS;
            end
            BIAS: begin
               b_q    <= b_new;
               sat_q  <= sat_q | b_ovf;
               busy_q <= 1'b0;
               done_q <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
   for (genvar i = 0; i < N_INPUTS; i++) begin : g_w
      assign bus.weight_flat[i*DATA_W +: DATA_W] = w[i];
   end
   assign bus.bias = b_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sat  = sat_q;
endmodule

// File: tb/tb_neuron_weight_update.sv
// tb_neuron_weight_update: directed vector table plus collision and reset sequences for neuron_weight_update
module tb_neuron_weight_update;
   import neuron_pkg::*;
   localparam int N = 4;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int checks = 0;
   int errors = 0;
   neuron_weight_update_if #(.N_INPUTS(N)) bus ();
   neuron_weight_update #(.N_INPUTS(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   typedef struct {
      logic [31:0]        w_in;
      logic signed [7:0]  b_in;
      logic signed [7:0]  err;
      logic [31:0]        x;
      logic [31:0]        w_exp;
      logic signed [7:0]  b_exp;
      logic               sat_exp;
   } vec_t;
   vec_t v [7];
   function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
      logic [31:0] r;
      r[7:0]   = a[7:0];
      r[15:8]  = b[7:0];
      r[23:16] = c[7:0];
      r[31:24] = d[7:0];
      return r;
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic wr(input int a, input int d);
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a[2:0];
      bus.wr_data = d[7:0];
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask
   task automatic load(input logic [31:0] w, input logic signed [7:0] b);
      for (int i = 0; i < N; i++) wr(i, int'(w[i*8 +: 8]));
      wr(N, int'(b));
   endtask
   task automatic run(input logic signed [7:0] e, input logic [31:0] x, output int lat);
      @(negedge clk);
      bus.err    = e;
      bus.x_flat = x;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.err    = 8'sh55;
      bus.x_flat = 32'ha5a5_a5a5;
      chk("busy_after_start", 32'(bus.busy), 1);
      lat = 0;
      while (!bus.done && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask
   task automatic count_done(input int n, output int c);
      c = 0;
      repeat (n) begin
         @(negedge clk);
         if (bus.done) c++;
      end
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, "_weights"}, bus.weight_flat, 0);
      chk({tag, "_bias"}, bus.bias, 0);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
      chk({tag, "_done"}, 32'(bus.done), 0);
      chk({tag, "_sat"}, 32'(bus.sat), 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
   initial begin
      int lat, c;
      bus.start = 1'b0; bus.err = '0; bus.x_flat = '0;
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      v[0] = '{pk(64,0,0,0),      8'sd0,    8'sd16,   pk(32,0,0,0),       pk(62,0,0,0),       -8'sd4,  1'b0};
      v[1] = '{pk(0,-120,0,0),    8'sd0,    8'sd127,  pk(0,127,0,0),      pk(0,-128,0,0),     -8'sd31, 1'b1};
      v[2] = '{pk(10,20,30,40),   8'sd5,    8'sd8,    pk(64,-64,32,0),    pk(8,22,29,40),     8'sd3,   1'b0};
      v[3] = '{pk(0,0,0,0),       8'sd0,    -8'sd1,   pk(1,0,0,0),        pk(1,0,0,0),        8'sd1,   1'b0};
      v[4] = '{pk(127,0,0,0),     8'sd0,    8'sh80,   pk(127,0,0,0),      pk(127,0,0,0),      8'sd32,  1'b1};
      v[5] = '{pk(0,0,0,0),       -8'sd120, 8'sd127,  pk(0,0,0,0),        pk(0,0,0,0),        8'sh80,  1'b1};
      v[6] = '{pk(-5,100,-100,0), -8'sd10,  -8'sd100, pk(-100,50,-50,127), pk(-44,120,-119,50), 8'sd15,  1'b0};
      #2 rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      load(pk(1,2,3,4), 8'sd9);
      run(8'sd127, pk(0,0,0,0), lat);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 chk_zero("async_reset");
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         load(v[i].w_in, v[i].b_in);
         run(v[i].err, v[i].x, lat);
         chk($sformatf("v%0d_latency", i), lat, 5);
         chk($sformatf("v%0d_weights", i), bus.weight_flat, v[i].w_exp);
         chk($sformatf("v%0d_bias", i), bus.bias, v[i].b_exp);
         chk($sformatf("v%0d_sat", i), 32'(bus.sat), 32'(v[i].sat_exp));
         chk($sformatf("v%0d_busy_in_done", i), 32'(bus.busy), 0);
         @(negedge clk);
         chk($sformatf("v%0d_done_one_cycle", i), 32'(bus.done), 0);
      end
      // start pulsed again while busy must be dropped, not queued
      load(pk(0,0,0,0), 8'sd0);
      @(negedge clk) begin bus.err = 8'sd4; bus.x_flat = '0; bus.start = 1'b1; end
      @(negedge clk) bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      count_done(10, c);
      chk("busy_start_done_count", c, 1);
      chk("busy_start_bias", bus.bias, -1);
      // writes while busy are ignored
      load(pk(7,0,0,0), 8'sd0);
      @(negedge clk) begin bus.err = 8'sd0; bus.x_flat = '0; bus.start = 1'b1; end
      @(negedge clk) begin bus.start = 1'b0; bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 8'sd99; end
      @(negedge clk) begin bus.wr_addr = 3'd4; bus.wr_data = 8'sd55; end
      @(negedge clk) bus.wr_en = 1'b0;
      count_done(10, c);
      chk("busy_wr_done_count", c, 1);
      chk("busy_wr_weights", bus.weight_flat, pk(7,0,0,0));
      chk("busy_wr_bias", bus.bias, 0);
      // start and wr_en together in IDLE: the update wins
      load(pk(7,0,0,0), 8'sd0);
      @(negedge clk) begin
         bus.err = 8'sd16; bus.x_flat = pk(32,0,0,0); bus.start = 1'b1;
         bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_data = 8'sd50;
      end
      @(negedge clk) begin bus.start = 1'b0; bus.wr_en = 1'b0; end
      count_done(10, c);
      chk("start_wr_done_count", c, 1);
      chk("start_wr_weights", bus.weight_flat, pk(5,0,0,0));
      chk("start_wr_bias", bus.bias, -4);
      // reset just after E2 of an update
      load(pk(10,20,30,40), 8'sd5);
      @(negedge clk) begin bus.err = 8'sd127; bus.x_flat = pk(0,127,0,0); bus.start = 1'b1; end
      @(negedge clk) bus.start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1 chk_zero("mid_reset");
      @(negedge clk) rst = 1'b0;
      count_done(10, c);
      chk("mid_reset_no_done", c, 0);
      load(v[2].w_in, v[2].b_in);
      run(v[2].err, v[2].x, lat);
      chk("post_reset_latency", lat, 5);
      chk("post_reset_weights", bus.weight_flat, v[2].w_exp);
      chk("post_reset_bias", bus.bias, v[2].b_exp);
      chk("post_reset_sat", 32'(bus.sat), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/neuron_weight_update.md
# neuron_weight_update

Backward-pass companion to the neuron accumulate datapath. It holds the neuron's signed 8-bit weights and bias and, on each `start`, applies one gradient step to them. Each weight `w[i]` is reduced by `(err*x[i]) >>> LR_SHIFT`, and the bias is reduced by `err >>> BIAS_SHIFT`, with saturation. The registered weights and bias drive the forward accumulator's `weight`/`bias` inputs. A small write port loads initial values.

## Interface
- `N_INPUTS`, default 4: number of weights and inputs; index width is `$clog2(N_INPUTS)`.
- `LR_SHIFT`, default 8: arithmetic right shift applied to the 16-bit `err*x` product. The default of 8 matches the forward path's top-byte scaling.
- `BIAS_SHIFT`, default 2: arithmetic right shift applied to `err` for the bias step.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to perform an update; sampled only in IDLE.
- `err` in 8 signed: error term; latched at start accept.
- `x_flat` in `N_INPUTS*8` signed: input vector, with `x[i] = x_flat[i*8 +: 8]`; latched at start accept.
- `wr_en` in 1: initial-value write strobe; honoured only in IDLE when `start` is low.
- `wr_addr` in `$clog2(N_INPUTS+1)`: addresses 0..N_INPUTS-1 select a weight; address N_INPUTS selects the bias; larger addresses are ignored.
- `wr_data` in 8 signed: value to write.
- `weight_flat` out `N_INPUTS*8` signed: registered weights; reset value 0.
- `bias` out 8 signed: registered bias; reset value 0.
- `busy` out 1: high whenever the state is not IDLE; reset value 0.
- `done` out 1: one-cycle pulse when an update completes; reset value 0.
- `sat` out 1: sticky flag, set if any clamp occurred during the last update; cleared at start accept; reset value 0.

## Operation
- The FSM has three states: IDLE, UPD, BIAS.
  - IDLE -> UPD on `start`. At the same edge: latch `err` and `x_flat`, set `idx=0`, clear `sat`.
  - UPD: each edge writes `w[idx]` and increments `idx`. When `idx==N_INPUTS-1`, the next state is BIAS.
  - BIAS: one edge writes `bias`, the state returns to IDLE, and `done` goes high for exactly one cycle.
- Weight arithmetic:
  - `prod = err*x[idx]` is a 16-bit signed product.
  - `delta = prod >>> LR_SHIFT` (arithmetic shift, floor rounding).
  - `diff = w - delta` is computed at 17 bits.
  - The result is clamped to [-128, 127]. Any clamp sets `sat`.
- Bias arithmetic: `diff = bias - (err >>> BIAS_SHIFT)` at 9 bits, clamped the same way, and a clamp sets `sat`.
- Only the latched `err` and `x` are used. Input changes after start accept have no effect.
- `start` while `busy` is ignored and is not queued.
- `wr_en` while `busy` is ignored.
- When `start` and `wr_en` are both high in IDLE, `start` wins and the write is dropped.
- Writes take effect at the edge and do not affect `sat` or `done`.
- When `rst` is asserted in any state, including mid-update:
  - all weights, bias, `idx`, `sat`, `done` and `busy` go to 0 and the state goes to IDLE;
  - the interrupted update produces no `done`.

## Timing
- Start is accepted at edge E0.
- `w[i]` is written at edge E(i+1).
- `bias` is written at edge E(N_INPUTS+1).
- `done` is high in the cycle following E(N_INPUTS+1). Total latency from start to done is N_INPUTS+1 cycles, which is 5 at the default.
- `busy` is high from E0 through E(N_INPUTS+1) and is low in the `done` cycle.
- The earliest next `start` is accepted at the edge that ends the `done` cycle, giving back-to-back throughput of one update per N_INPUTS+2 cycles.
- Updated weight values are visible on `weight_flat` the cycle after their write edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `neuron_pkg` holds:
  - `DATA_W=8` and `PROD_W=16`;
  - `SAT_MAX=127` and `SAT_MIN=-128`;
  - the state enum `upd_state_t` {IDLE, UPD, BIAS}.
- One combinational sub-module, `sat_sub`, computes `a - b` on a widened signed input and saturates the result to 8 bits, with an overflow flag. It is instantiated twice: once for the weight path and once for the bias path.
- The weights are a register array, not inferred RAM; the only mux is the one driven by `idx`.

## Test plan
1. Reset: assert `rst` asynchronously mid-cycle. Expect all weights = 0, `bias` = 0, and `busy`/`done`/`sat` = 0 immediately, without waiting for a clock edge.
2. Basic step: write `w0=64` and leave other weights at 0. Apply `err=16`, `x=[32,0,0,0]`, then `start`. Expect:
   - `w=[62,0,0,0]` and `bias=-4`;
   - `done` 5 cycles after start and `sat=0`.
3. Saturation: write `w1=-120`. Apply `err=127`, `x1=127`. The product is 16129 and delta = 63. Expect `w1=-128` and `sat=1`. Follow with a clean update and expect `sat` back to 0.
4. Floor rounding: with `w0=0`, apply `err=-1`, `x0=1`. The product is -1 and delta = -1. Expect `w0=1`; the bias step is `-1>>>2 = -1`, so `bias=1`.
5. Collisions:
   - `start` asserted while `busy`: expect exactly one `done`.
   - `wr_en` while `busy`: expect no write.
   - `start` and `wr_en` together in IDLE: expect the write dropped and the update run.
6. Reset mid-update: assert `rst` at E2 of an update. Expect all values 0, no `done` pulse, and a subsequent `start` to run normally.
